// File: rtl/fifo_ctrl_ram128.sv
// fifo_ctrl_ram128 -- first-word-fall-through FIFO controller for a 128x8
// dual-port RAM with a synchronous, active-low write port and an
// asynchronous read port.
//
// The controller holds only the write/read pointers, the occupancy count
// and, optionally, the sticky error flags. The data words live in the
// external RAM. The head of the queue is always the RAM word at the read
// pointer, so rd_data is valid whenever empty=0 with zero pop latency.
//
// Handshake: a push is accepted (push_ok) when wr_en=1 and the FIFO is not
// full, or when it is full and a pop is accepted in the same cycle. A pop is
// accepted (pop_ok) when rd_en=1 and the FIFO is not empty. There is no
// ready output. A request that is not accepted is dropped and, with error
// tracking built in, is recorded in ovf/udf.
//
// Build option: define FIFO_ERR_EN to build the sticky ovf/udf flag
// registers. Without it, ovf/udf read as 0 and err_clr is ignored.

module fifo_ctrl_ram128 #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          err_clr,
  output logic          ovf,
  output logic          udf,
  output logic          ram_we_n,
  output logic [AW-1:0] ram_adr_a,
  output logic [AW-1:0] ram_adr_b,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // Occupancy of a completely full FIFO (2**AW), held at count width.
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic push_ok;
  logic pop_ok;

  // Status flags decode from the count register only, so they change on
  // clock edges or reset and never follow the request inputs.
  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == '0);
    count = count_q;
  end

  // Request acceptance. A push into a full FIFO rides on a same-cycle pop:
  // the new word lands in the slot the head is vacating.
  always_comb begin
    pop_ok  = rd_en & ~empty;
    push_ok = wr_en & (~full | pop_ok);
  end

  // RAM-side wiring. The write strobe is held inactive during reset so
  // nothing is written while the pointers are being cleared.
  always_comb begin
    ram_we_n  = rst | ~push_ok;
    ram_adr_a = wptr_q;
    ram_adr_b = rptr_q;
    ram_din   = wr_data;
    rd_data   = ram_dout;
  end

  // Next pointers and occupancy. Pointers wrap naturally at 2**AW.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards the contents at once.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = (wr_en & ~push_ok) | (ovf_q & ~err_clr);
    udf_d = (rd_en & ~pop_ok)  | (udf_q & ~err_clr);
    ovf   = ovf_q;
    udf   = udf_q;
  end

  // Error flag registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`else
  logic unused_err_clr;

  // Error tracking not built: flags tie low and the clear input is unused.
  always_comb begin
    ovf            = 1'b0;
    udf            = 1'b0;
    unused_err_clr = err_clr;
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_ram128.sv
// tb_fifo_ctrl_ram128 -- directed bench for fifo_ctrl_ram128 with a
// behavioural 128x8 RAM (synchronous active-low write, asynchronous read)
// attached. Expected data comes from a queue of pushed words; expected
// pointers, count and flags come from a small reference model.
// Define FIFO_ERR_EN for both bench and RTL to check the sticky flags.

module tb_fifo_ctrl_ram128;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          ck;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          err_clr;
  logic          ovf;
  logic          udf;
  logic          ram_we_n;
  logic [AW-1:0] ram_adr_a;
  logic [AW-1:0] ram_adr_b;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // ---------------- clock / reset ----------------
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // ---------------- DUT + RAM model ----------------
  fifo_ctrl_ram128 #(.DW(DW), .AW(AW)) dut (
    .ck        (ck),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .err_clr   (err_clr),
    .ovf       (ovf),
    .udf       (udf),
    .ram_we_n  (ram_we_n),
    .ram_adr_a (ram_adr_a),
    .ram_adr_b (ram_adr_b),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge ck) begin
    if (!ram_we_n) mem[ram_adr_a] <= ram_din;
  end
  assign ram_dout = mem[ram_adr_b];

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_wptr;
  int            exp_rptr;
  logic          exp_ovf;
  logic          exp_udf;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_wptr = 0;
    exp_rptr = 0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  // Flags and occupancy after an edge.
  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
    chk({tag, ".adr_a"}, 32'(ram_adr_a), 32'(exp_wptr));
    chk({tag, ".adr_b"}, 32'(ram_adr_b), 32'(exp_rptr));
`ifdef FIFO_ERR_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(exp_udf));
`else
    chk({tag, ".ovf"}, 32'(ovf), 32'd0);
    chk({tag, ".udf"}, 32'(udf), 32'd0);
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply requests after the falling edge, check the
  // combinational outputs, take the rising edge, then check status.
  task automatic op(input string tag, input logic w, input logic [DW-1:0] d,
                    input logic r, input logic clr);
    logic do_pop, do_push;
    @(negedge ck);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = clr;
    do_pop  = r && (exp_q.size() > 0);
    do_push = w && ((exp_q.size() < DEPTH) || do_pop);
    #1;
    chk({tag, ".we_n"}, 32'(ram_we_n), 32'(!do_push));
    if (do_pop) chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
    @(posedge ck);
    if (do_pop) begin
      void'(exp_q.pop_front());
      exp_rptr = (exp_rptr + 1) % DEPTH;
    end
    if (do_push) begin
      exp_q.push_back(d);
      exp_wptr = (exp_wptr + 1) % DEPTH;
    end
    exp_ovf = (w && !do_push) || (exp_ovf && !clr);
    exp_udf = (r && !do_pop)  || (exp_udf && !clr);
    #1;
    chk_status(tag);
  endtask

  task automatic idle();
    @(negedge ck);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    model_reset();

    // Reset then idle.
    #12;
    chk("rst.we_n", 32'(ram_we_n), 32'd1);
    chk_status("rst");
    @(negedge ck);
    rst = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    chk_status("idle");

    // Fill with 0x00..0x7F, then drain in order.
    for (int i = 0; i < DEPTH; i++) op("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill.full_flag", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) op("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.empty_flag", 32'(empty), 32'd1);

    // Fill, pop 10, push 0xA0..0xA9 across the pointer wrap, drain.
    for (int i = 0; i < DEPTH; i++) op("wfill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)    op("wpop", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)    op("wpush", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("wrap.adr_a", 32'(ram_adr_a), 32'd10);
    for (int i = 0; i < DEPTH; i++) op("wdrain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full with simultaneous push+pop for 5 cycles, then a rejected push.
    for (int i = 0; i < DEPTH; i++) op("ffill", 1'b1, 8'(i ^ 8'h33), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)     op("fboth", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    chk("fboth.count", 32'(count), 32'd128);
    op("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
    op("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    op("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) op("fdrain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with simultaneous push+pop: push wins, pop is an underflow.
    op("eboth", 1'b1, 8'h55, 1'b1, 1'b0);
    chk("eboth.count", 32'(count), 32'd1);
    chk("eboth.rd_data", 32'(rd_data), 32'h55);
    op("udf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    op("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    op("epop", 1'b0, 8'h00, 1'b1, 1'b0);
    op("udf_setwin", 1'b0, 8'h00, 1'b1, 1'b1);
    op("udf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to 64, then reset mid-cycle with a push request pending.
    for (int i = 0; i < 64; i++) op("rfill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    @(negedge ck);
    wr_en   = 1'b1;
    wr_data = 8'h99;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mrst.we_n", 32'(ram_we_n), 32'd1);
    chk_status("mrst");
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    op("rpush", 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("rpush.rd_data", 32'(rd_data), 32'h3C);
    op("rpop", 1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
